mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Shared memory port bundle: fetch and data requesters
// on one side, the single-port memory macro on the other.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_flush;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_WIDTH-1:0] dm_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and MEM stage,
// with fixed read latency, flush kill and bounded data priority.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_LATENCY   = 2,
  parameter int MAX_DM_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);
  localparam logic [2:0] S_MAX  = 3'(MAX_DM_STREAK);

  state_t     state;
  logic [2:0] cnt;
  logic       owner;
  logic       kill;
  logic [2:0] streak;

  logic ret, slot;
  logic pick_dm, pick_if, rd_issue;
  logic if_ok, dm_ok;

  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [DATA_WIDTH-1:0] wdata_mux;
  logic                  we_mux;

  always_comb begin
    ret      = (state == RD_WAIT) && (cnt == 3'd0);
    slot     = rst_n && ((state == IDLE) || ret);
    pick_dm  = slot && bus.dm_req &&
               (!bus.if_req || (streak != S_MAX));
    pick_if  = slot && bus.if_req && !pick_dm;
    rd_issue = pick_if || (pick_dm && !bus.dm_we);
    // fetch return is dropped if a flush landed now or earlier
    if_ok    = rst_n && ret && !owner && !kill &&
               !bus.if_flush;
    dm_ok    = rst_n && ret && owner;
  end

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    we_mux    = 1'b0;
    unique case (1'b1)
      pick_dm: begin
        addr_mux  = bus.dm_addr;
        wdata_mux = bus.dm_wdata;
        we_mux    = bus.dm_we;
      end
      pick_if: begin
        addr_mux  = bus.if_addr;
      end
      default: begin
        addr_mux  = '0;
      end
    endcase
  end

  assign bus.if_gnt    = pick_if;
  assign bus.dm_gnt    = pick_dm;
  assign bus.mem_en    = pick_if || pick_dm;
  assign bus.mem_we    = we_mux;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.if_rvalid = if_ok;
  assign bus.if_rdata  = if_ok ? bus.mem_rdata : '0;
  assign bus.dm_rvalid = dm_ok;
  assign bus.dm_rdata  = dm_ok ? bus.mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      owner  <= 1'b0;
      kill   <= 1'b0;
      streak <= 3'd0;
    end else begin
      if (rd_issue) begin
        state <= RD_WAIT;
        cnt   <= LAT_M1;
        owner <= pick_dm;
        kill  <= 1'b0;
      end else if (state == RD_WAIT) begin
        if (cnt != 3'd0) begin
          cnt <= cnt - 3'd1;
          if (bus.if_flush && !owner) kill <= 1'b1;
        end else begin
          state <= IDLE;
        end
      end
      if (pick_if) begin
        streak <= 3'd0;
      end else if (pick_dm && bus.if_req &&
                   (streak != S_MAX)) begin
        streak <= streak + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed
// corner sequences and a read-return scoreboard.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b();
  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b1();

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MEM_LATENCY(2), .MAX_DM_STREAK(3)
  ) u_dut (.clk(clk), .rst_n(rst_n), .bus(b.slave));

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MEM_LATENCY(1), .MAX_DM_STREAK(3)
  ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  // behavioural memory for the latency-2 instance
  logic [31:0] mem [0:63];
  logic [31:0] pipe [0:LAT-1];
  bit init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++)
        mem[i] <= (i == 16) ? 32'hDEADBEEF
                            : 32'h1000_0000 + 32'(i);
      init_done <= 1'b1;
    end else if (b.mem_en && b.mem_we) begin
      mem[b.mem_addr[7:2]] <= b.mem_wdata;
    end
    pipe[0] <= (b.mem_en && !b.mem_we) ?
               mem[b.mem_addr[7:2]] : 32'hFFFF_FFFF;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign b.mem_rdata = pipe[LAT-1];

  // latency-1 memory: data is a fixed function of address
  logic [31:0] rd1;
  always @(posedge clk)
    rd1 <= b1.mem_en ? (b1.mem_addr ^ 32'h5A5A_0000)
                     : 32'hFFFF_FFFF;
  assign b1.mem_rdata = rd1;

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // scoreboard of outstanding reads on the latency-2 instance
  typedef struct {
    bit          dm;
    logic [31:0] data;
    int          due;
    bit          killed;
  } exp_t;
  exp_t q[$];

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
    end else begin
      for (int i = 0; i < q.size(); i++)
        if (!q[i].dm && b.if_flush) q[i].killed = 1'b1;
      if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk1("sb_dm_rvalid", b.dm_rvalid, e.dm);
        chk1("sb_if_rvalid", b.if_rvalid, !e.dm && !e.killed);
        chk32("sb_dm_rdata", b.dm_rdata,
              e.dm ? e.data : 32'h0);
        chk32("sb_if_rdata", b.if_rdata,
              (!e.dm && !e.killed) ? e.data : 32'h0);
      end else begin
        chk1("sb_spurious_dm_rvalid", b.dm_rvalid, 1'b0);
        chk1("sb_spurious_if_rvalid", b.if_rvalid, 1'b0);
      end
      if (!b.mem_en) chk32("mem_addr_idle", b.mem_addr, 32'h0);
      if (b.if_gnt)
        q.push_back('{1'b0, mem[b.if_addr[7:2]],
                      cyc + LAT, 1'b0});
      if (b.dm_gnt && !b.dm_we)
        q.push_back('{1'b1, mem[b.dm_addr[7:2]],
                      cyc + LAT, 1'b0});
    end
  end

  task automatic clear_in();
    b.if_req   = 1'b0;
    b.if_addr  = '0;
    b.if_flush = 1'b0;
    b.dm_req   = 1'b0;
    b.dm_we    = 1'b0;
    b.dm_addr  = '0;
    b.dm_wdata = '0;
    b1.if_req   = 1'b0;
    b1.if_addr  = '0;
    b1.if_flush = 1'b0;
    b1.dm_req   = 1'b0;
    b1.dm_we    = 1'b0;
    b1.dm_addr  = '0;
    b1.dm_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk1({nm, "_ctl"}, |{b.if_gnt, b.if_rvalid, b.dm_gnt,
                         b.dm_rvalid, b.mem_en, b.mem_we,
                         b1.if_gnt, b1.mem_en}, 1'b0);
    chk32({nm, "_bus"}, b.if_rdata | b.dm_rdata |
                        b.mem_addr | b.mem_wdata, 32'h0);
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    clear_in();
    @(negedge clk);
    chk_all_zero("reset_outputs");
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        ir, dr, dwe;
    logic [31:0] ia, da, dwd;
    logic        eig, edg, een, ewe;
    logic [31:0] ea, ewd;
  } vec_t;
  vec_t vt [8];

  initial begin
    vt[0] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
              1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0,
              1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h40, 32'h99,
              1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h99};
    vt[3] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h10, 32'h5,
              1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 32'h5};
    vt[4] = '{1'b1, 1'b1, 1'b0, 32'h104, 32'h44, 32'h0,
              1'b0, 1'b1, 1'b1, 1'b0, 32'h44, 32'h0};
    vt[5] = '{1'b1, 1'b1, 1'b1, 32'h108, 32'h20, 32'h77,
              1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h77};
    vt[6] = '{1'b1, 1'b1, 1'b1, 32'h10C, 32'h24, 32'h88,
              1'b0, 1'b1, 1'b1, 1'b1, 32'h24, 32'h88};
    // third data win in a row: fetch must now take the port
    vt[7] = '{1'b1, 1'b1, 1'b1, 32'h110, 32'h28, 32'h99,
              1'b1, 1'b0, 1'b1, 1'b0, 32'h110, 32'h0};

    clear_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("por_outputs");
    step();
    rst_n = 1'b1;

    for (int n = 0; n < 8; n++) begin
      step();
      b.if_req   = vt[n].ir;
      b.if_addr  = vt[n].ia;
      b.dm_req   = vt[n].dr;
      b.dm_we    = vt[n].dwe;
      b.dm_addr  = vt[n].da;
      b.dm_wdata = vt[n].dwd;
      @(negedge clk);
      chk1("vec_if_gnt", b.if_gnt, vt[n].eig);
      chk1("vec_dm_gnt", b.dm_gnt, vt[n].edg);
      chk1("vec_mem_en", b.mem_en, vt[n].een);
      chk1("vec_mem_we", b.mem_we, vt[n].ewe);
      chk32("vec_mem_addr", b.mem_addr, vt[n].ea);
      chk32("vec_mem_wdata", b.mem_wdata, vt[n].ewd);
      step();
      clear_in();
      repeat (LAT) step();
    end

    // single load
    do_reset();
    step();
    b.dm_req = 1'b1; b.dm_addr = 32'h40;
    @(negedge clk);
    chk1("ld_gnt", b.dm_gnt, 1'b1);
    chk1("ld_mem_en", b.mem_en, 1'b1);
    chk32("ld_mem_addr", b.mem_addr, 32'h40);
    step();
    clear_in();
    @(negedge clk);
    chk1("ld_rvalid_early", b.dm_rvalid, 1'b0);
    step();
    @(negedge clk);
    chk1("ld_rvalid", b.dm_rvalid, 1'b1);
    chk32("ld_rdata", b.dm_rdata, 32'hDEADBEEF);
    chk1("ld_if_rvalid", b.if_rvalid, 1'b0);

    // contention
    do_reset();
    for (int k = 0; k < 16; k++) begin
      step();
      b.if_req = 1'b1; b.if_addr = 32'h180;
      b.dm_req = 1'b1; b.dm_addr = 32'h40;
      @(negedge clk);
      if (k % 2 == 0) begin
        chk1("cont_if_gnt", b.if_gnt, (k / 2) % 4 == 3);
        chk1("cont_dm_gnt", b.dm_gnt, (k / 2) % 4 != 3);
      end else begin
        chk1("cont_gap", b.if_gnt | b.dm_gnt, 1'b0);
      end
    end
    step();
    clear_in();
    repeat (LAT + 1) step();

    // store then fetch
    do_reset();
    step();
    b.dm_req = 1'b1; b.dm_we = 1'b1;
    b.dm_addr = 32'h10; b.dm_wdata = 32'h5;
    b.if_req = 1'b1; b.if_addr = 32'h80;
    @(negedge clk);
    chk1("st_gnt", b.dm_gnt, 1'b1);
    chk1("st_we", b.mem_we, 1'b1);
    chk32("st_wdata", b.mem_wdata, 32'h5);
    chk1("st_if_wait", b.if_gnt, 1'b0);
    step();
    b.dm_req = 1'b0; b.dm_we = 1'b0;
    @(negedge clk);
    chk1("st_if_gnt", b.if_gnt, 1'b1);
    chk32("st_if_addr", b.mem_addr, 32'h80);
    step();
    b.if_req = 1'b0;
    @(negedge clk);
    chk1("st_if_rvalid_early", b.if_rvalid, 1'b0);
    step();
    @(negedge clk);
    chk1("st_if_rvalid", b.if_rvalid, 1'b1);
    chk32("st_if_rdata", b.if_rdata, 32'h1000_0020);

    // flush kills the in-flight fetch
    do_reset();
    step();
    b.if_req = 1'b1; b.if_addr = 32'h84;
    @(negedge clk);
    chk1("fl_if_gnt", b.if_gnt, 1'b1);
    step();
    b.if_req = 1'b0; b.if_flush = 1'b1;
    b.dm_req = 1'b1; b.dm_addr = 32'h48;
    @(negedge clk);
    chk1("fl_wait_gnt", b.dm_gnt, 1'b0);
    step();
    b.if_flush = 1'b0;
    @(negedge clk);
    chk1("fl_if_rvalid", b.if_rvalid, 1'b0);
    chk1("fl_dm_gnt", b.dm_gnt, 1'b1);
    step();
    clear_in();
    step();
    @(negedge clk);
    chk1("fl_dm_rvalid", b.dm_rvalid, 1'b1);
    chk32("fl_dm_rdata", b.dm_rdata, 32'h1000_0012);

    // latency-1 back-to-back fetch
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step();
      b1.if_req = 1'b1;
      b1.if_addr = 32'h200 + 32'(4 * k);
      @(negedge clk);
      chk1("l1_if_gnt", b1.if_gnt, 1'b1);
      chk1("l1_if_rvalid", b1.if_rvalid, k != 0);
      if (k != 0)
        chk32("l1_if_rdata", b1.if_rdata,
              (32'h200 + 32'(4 * (k - 1))) ^ 32'h5A5A_0000);
    end
    step();
    clear_in();
    step();

    // reset in the middle of a load
    do_reset();
    step();
    b.dm_req = 1'b1; b.dm_addr = 32'h4C;
    @(negedge clk);
    chk1("rst_ld_gnt", b.dm_gnt, 1'b1);
    step();
    rst_n = 1'b0;
    b.dm_addr = 32'h50; b.if_req = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_mid1");
    step();
    @(negedge clk);
    chk_all_zero("rst_mid2");
    step();
    rst_n = 1'b1;
    b.if_req = 1'b0;
    @(negedge clk);
    chk1("rst_new_gnt", b.dm_gnt, 1'b1);
    chk32("rst_new_addr", b.mem_addr, 32'h50);
    chk1("rst_no_rvalid", b.dm_rvalid, 1'b0);
    step();
    clear_in();
    repeat (LAT + 3) step();
    @(negedge clk);
    chk1("sb_drained", q.size() == 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
